// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one main-memory port between I-cache block fills,
// D-cache block fills and D-cache write-through stores.
//
// Handshakes: every request (I_miss, D_miss, D_st) is a level held by the
// requester until its completion strobe (fill_done_I, fill_done_D, st_done).
// That strobe acts as the "ready" half of the pair. The requester drops the
// level on the clock edge that ends the strobe cycle. Requests are looked at
// only while the FSM sits in IDLE. mem_data_valid has no back-pressure: every
// beat seen in ISSUE or DRAIN is consumed that same cycle.
module mem_fill_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_miss,
    input  logic [15:0] I_miss_addr,
    input  logic        D_miss,
    input  logic [15:0] D_miss_addr,
    input  logic        D_st,
    input  logic [15:0] D_st_addr,
    input  logic [15:0] D_st_data,
    input  logic [15:0] mem_data_in,
    input  logic        mem_data_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_out,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        fill_wr_I,
    output logic        fill_wr_D,
    output logic        fill_done_I,
    output logic        fill_done_D,
    output logic        st_done,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STORE = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  issue_cnt;
    logic [2:0]  rx_cnt;
    logic [11:0] base_blk;   // block number of the fill in progress
    logic        gnt_d;      // side of the fill in progress: 1 = D, 0 = I
    logic        last_d;     // side of the last completed fill: 1 = D, 0 = I
    logic        fill_req;
    logic        pick_d;
    logic        rx_fire;
    logic        rx_last;

    // The word offset inside a block is regenerated from issue_cnt, so the
    // low miss-address bits are intentionally not used.
    logic unused_lo;
    assign unused_lo = ^{I_miss_addr[3:0], D_miss_addr[3:0]};

    // Fill arbitration: a tie goes to the side that did not win last time.
    always_comb begin
        fill_req = I_miss | D_miss;
        if (I_miss && D_miss) begin
            pick_d = ~last_d;
        end else begin
            pick_d = D_miss;
        end
    end

    assign rx_fire = mem_data_valid && ((state == S_ISSUE) || (state == S_DRAIN));
    assign rx_last = rx_fire && (rx_cnt == 3'd7);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: stores win over fills, and the 8th beat ends a fill
    // from either ISSUE or DRAIN.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (D_st) begin
                    state_nx = S_STORE;
                end else if (fill_req) begin
                    state_nx = S_ISSUE;
                end
            end
            S_STORE: state_nx = S_IDLE;
            S_ISSUE: begin
                if (rx_last) begin
                    state_nx = S_DONE;
                end else if (issue_cnt == 3'd7) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rx_last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Fill bookkeeping: latch the block and side on grant, count issued and
    // returned words, and remember the winner once the fill completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= 3'd0;
            rx_cnt    <= 3'd0;
            base_blk  <= 12'h000;
            gnt_d     <= 1'b0;
            last_d    <= 1'b0;
        end else begin
            if ((state == S_IDLE) && !D_st && fill_req) begin
                base_blk  <= pick_d ? D_miss_addr[15:4] : I_miss_addr[15:4];
                gnt_d     <= pick_d;
                issue_cnt <= 3'd0;
                rx_cnt    <= 3'd0;
            end
            if (state == S_ISSUE) begin
                issue_cnt <= issue_cnt + 3'd1;
            end
            if (rx_fire) begin
                rx_cnt <= rx_cnt + 3'd1;
            end
            if (state == S_DONE) begin
                last_d <= gnt_d;
            end
        end
    end

    // Outputs: the memory command comes from the state, and the fill strobes
    // follow returned beats combinationally.
    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_out = 16'h0000;
        fill_data    = 16'h0000;
        fill_word    = 3'd0;
        fill_wr_I    = 1'b0;
        fill_wr_D    = 1'b0;
        fill_done_I  = 1'b0;
        fill_done_D  = 1'b0;
        st_done      = 1'b0;
        case (state)
            S_STORE: begin
                mem_en       = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = D_st_addr;
                mem_data_out = D_st_data;
                st_done      = 1'b1;
            end
            S_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = {base_blk, 4'h0} + {12'h000, issue_cnt, 1'b0};
            end
            S_DONE: begin
                fill_done_I = ~gnt_d;
                fill_done_D = gnt_d;
            end
            default: ;
        endcase
        if (rx_fire) begin
            fill_data = mem_data_in;
            fill_word = rx_cnt;
            fill_wr_I = ~gnt_d;
            fill_wr_D = gnt_d;
        end
        busy      = (state != S_IDLE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: directed bench for mem_fill_arbiter with a small
// latency-configurable memory model and a fill-word scoreboard.
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        I_miss = 1'b0;
    logic [15:0] I_miss_addr = 16'h0000;
    logic        D_miss = 1'b0;
    logic [15:0] D_miss_addr = 16'h0000;
    logic        D_st = 1'b0;
    logic [15:0] D_st_addr = 16'h0000;
    logic [15:0] D_st_data = 16'h0000;
    logic [15:0] mem_data_in = 16'h0000;
    logic        mem_data_valid = 1'b0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_data_out, fill_data;
    logic [2:0]  fill_word, state_dbg;
    logic        fill_wr_I, fill_wr_D, fill_done_I, fill_done_D, st_done, busy;

    // Clock and reset block
    always #5 clk = ~clk;

    mem_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .I_miss(I_miss), .I_miss_addr(I_miss_addr),
        .D_miss(D_miss), .D_miss_addr(D_miss_addr),
        .D_st(D_st), .D_st_addr(D_st_addr), .D_st_data(D_st_data),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_wr_I(fill_wr_I), .fill_wr_D(fill_wr_D),
        .fill_done_I(fill_done_I), .fill_done_D(fill_done_D),
        .st_done(st_done), .busy(busy), .state_dbg(state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 4;
    bit spur    = 1'b0;
    int req_cyc;

    // Memory model: outstanding reads and the cycle their data comes back.
    logic [15:0] ret_addr_q[$];
    int          ret_due_q[$];

    // Scoreboard: expected {side_D, side_I, word, data} per fill strobe.
    logic [31:0] exp_q[$];

    // Observation logs for the current test.
    logic [15:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    int          st_cyc_q[$];
    logic [15:0] st_addr_q[$];
    logic [15:0] st_data_q[$];
    int          done_i_cyc_q[$];
    int          done_d_cyc_q[$];
    logic [1:0]  ev_q[$];        // 0 = I fill done, 1 = D fill done, 2 = store
    int          wr_cnt, first_wr_cyc, last_wr_cyc, extra_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    task automatic expect_fill(input bit side_d, input logic [15:0] miss_addr);
        logic [15:0] b;
        b = {miss_addr[15:4], 4'h0};
        for (int i = 0; i < 8; i++) begin
            logic [2:0] w;
            w = 3'(i);
            exp_q.push_back({11'b0, side_d, ~side_d, w, mem_word(b + 16'(2 * i))});
        end
    endtask

    task automatic clear_logs();
        rd_addr_q.delete(); rd_cyc_q.delete();
        st_cyc_q.delete(); st_addr_q.delete(); st_data_q.delete();
        done_i_cyc_q.delete(); done_d_cyc_q.delete(); ev_q.delete();
        wr_cnt = 0; first_wr_cyc = -1; last_wr_cyc = -1; extra_wr = 0;
    endtask

    // Driver: one clock cycle. Drive memory returns just after the edge, then
    // sample the settled outputs and play the requesters' side of the protocol.
    task automatic run_cycle();
        logic [31:0] got;
        logic [31:0] want;
        @(posedge clk);
        #1;
        cyc++;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;
        if (ret_due_q.size() > 0 && ret_due_q[0] == cyc) begin
            mem_data_valid = 1'b1;
            mem_data_in    = mem_word(ret_addr_q[0]);
            ret_due_q.delete(0);
            ret_addr_q.delete(0);
        end else if (spur) begin
            mem_data_valid = 1'b1;
            mem_data_in    = 16'hDEAD;
        end
        #1;
        if (mem_en && !mem_wr) begin
            rd_addr_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
            ret_addr_q.push_back(mem_addr);
            ret_due_q.push_back(cyc + lat);
        end
        if (mem_en && mem_wr) begin
            st_cyc_q.push_back(cyc);
            st_addr_q.push_back(mem_addr);
            st_data_q.push_back(mem_data_out);
        end
        if (st_done) begin
            ev_q.push_back(2'd2);
            D_st = 1'b0;
        end
        if (fill_wr_I || fill_wr_D) begin
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            got = {11'b0, fill_wr_D, fill_wr_I, fill_word, fill_data};
            if (exp_q.size() == 0) begin
                extra_wr++;
            end else begin
                want = exp_q.pop_front();
                check("fill_strobe", got, want);
            end
        end
        if (fill_done_I) begin
            done_i_cyc_q.push_back(cyc);
            ev_q.push_back(2'd0);
            I_miss = 1'b0;
        end
        if (fill_done_D) begin
            done_d_cyc_q.push_back(cyc);
            ev_q.push_back(2'd1);
            D_miss = 1'b0;
        end
    endtask

    task automatic do_reset();
        I_miss = 1'b0; D_miss = 1'b0; D_st = 1'b0; spur = 1'b0;
        ret_due_q.delete(); ret_addr_q.delete(); exp_q.delete();
        rst = 1'b1;
        run_cycle();
        run_cycle();
        rst = 1'b0;
    endtask

    task automatic check_sb(input string tag, input int n_wr);
        check({tag, "_wr_count"}, wr_cnt, n_wr);
        check({tag, "_extra_wr"}, extra_wr, 0);
        check({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state, including with requests and a valid beat applied.
        #1;
        check("rst_mem_cmd", {mem_en, mem_wr, mem_addr, mem_data_out[13:0]}, 32'h0);
        check("rst_fill", {fill_wr_I, fill_wr_D, fill_done_I, fill_done_D, st_done, busy, state_dbg}, 32'h0);
        I_miss = 1'b1; D_miss = 1'b1; D_st = 1'b1; mem_data_valid = 1'b1;
        #1;
        check("rst_hold_outputs", {mem_en, mem_wr, fill_wr_I, fill_wr_D, st_done, busy}, 32'h0);
        do_reset();

        // Single I fill, latency 4, from 0x1236.
        lat = 4;
        clear_logs();
        expect_fill(1'b0, 16'h1236);
        I_miss_addr = 16'h1236; I_miss = 1'b1; req_cyc = cyc;
        repeat (30) run_cycle();
        check("t1_rd_count", rd_addr_q.size(), 8);
        for (int i = 0; i < rd_addr_q.size() && i < 8; i++)
            check($sformatf("t1_rd_addr%0d", i), rd_addr_q[i], 16'h1230 + 16'(2 * i));
        check("t1_first_rd", rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1, req_cyc + 1);
        check("t1_rd_span", rd_cyc_q.size() == 8 ? rd_cyc_q[7] - rd_cyc_q[0] : -1, 7);
        check("t1_done_count", done_i_cyc_q.size() + done_d_cyc_q.size(), 1);
        check("t1_done_lat", done_i_cyc_q.size() > 0 ? done_i_cyc_q[0] - last_wr_cyc : -1, 1);
        check("t1_idle_after", {busy, I_miss}, 0);
        check_sb("t1", 8);

        // Tie after reset goes to D, then I; a second tie goes to D again.
        do_reset();
        clear_logs();
        expect_fill(1'b1, 16'h3458);
        expect_fill(1'b0, 16'h2000);
        I_miss_addr = 16'h2000; D_miss_addr = 16'h3458;
        I_miss = 1'b1; D_miss = 1'b1;
        repeat (60) run_cycle();
        check("t2_ev_count", ev_q.size(), 2);
        check("t2_first_is_D", ev_q.size() > 0 ? ev_q[0] : 2'd3, 1);
        check("t2_second_is_I", ev_q.size() > 1 ? ev_q[1] : 2'd3, 0);
        check("t2_first_rd", rd_addr_q.size() > 0 ? rd_addr_q[0] : 16'hFFFF, 16'h3450);
        check_sb("t2a", 16);
        clear_logs();
        expect_fill(1'b1, 16'h5000);
        expect_fill(1'b0, 16'h4000);
        I_miss_addr = 16'h4000; D_miss_addr = 16'h5000;
        I_miss = 1'b1; D_miss = 1'b1;
        repeat (60) run_cycle();
        check("t2_tie2_first_is_D", ev_q.size() > 0 ? ev_q[0] : 2'd3, 1);
        check("t2_tie2_second_is_I", ev_q.size() > 1 ? ev_q[1] : 2'd3, 0);
        check_sb("t2b", 16);

        // Store and D fill together: the store goes first.
        do_reset();
        clear_logs();
        expect_fill(1'b1, 16'h0100);
        D_st_addr = 16'h0040; D_st_data = 16'hBEEF; D_st = 1'b1;
        D_miss_addr = 16'h0100; D_miss = 1'b1; req_cyc = cyc;
        repeat (40) run_cycle();
        check("t3_st_count", st_cyc_q.size(), 1);
        check("t3_st_cyc", st_cyc_q.size() > 0 ? st_cyc_q[0] : -1, req_cyc + 1);
        check("t3_st_addr", st_addr_q.size() > 0 ? st_addr_q[0] : 16'hFFFF, 16'h0040);
        check("t3_st_data", st_data_q.size() > 0 ? st_data_q[0] : 16'h0000, 16'hBEEF);
        check("t3_order", ev_q.size() == 2 ? {ev_q[0], ev_q[1]} : 4'hF, 4'b1001);
        check("t3_first_rd", rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1, req_cyc + 3);
        check_sb("t3", 8);

        // Store raised during an I fill waits until the fill is done.
        do_reset();
        clear_logs();
        expect_fill(1'b0, 16'h0800);
        I_miss_addr = 16'h0800; I_miss = 1'b1;
        repeat (5) run_cycle();
        D_st_addr = 16'h0010; D_st_data = 16'h1234; D_st = 1'b1;
        repeat (40) run_cycle();
        check("t4_order", ev_q.size() == 2 ? {ev_q[0], ev_q[1]} : 4'hF, 4'b0010);
        check("t4_st_after_done",
              (st_cyc_q.size() > 0 && done_i_cyc_q.size() > 0) ? st_cyc_q[0] - done_i_cyc_q[0] : -1, 2);
        check("t4_st_addr", st_addr_q.size() > 0 ? st_addr_q[0] : 16'hFFFF, 16'h0010);
        check_sb("t4", 8);

        // Reset in DRAIN after 5 beats aborts the fill; the held miss refills.
        do_reset();
        clear_logs();
        expect_fill(1'b1, 16'h7772);
        D_miss_addr = 16'h7772; D_miss = 1'b1;
        for (int k = 0; k < 40 && wr_cnt < 5; k++) run_cycle();
        check("t5_five_beats", wr_cnt, 5);
        check("t5_in_drain", state_dbg, 3);
        rst = 1'b1;
        #1;
        check("t5_rst_outputs", {mem_en, mem_wr, fill_wr_I, fill_wr_D, fill_done_D, st_done, busy, state_dbg}, 0);
        exp_q.delete(); ret_due_q.delete(); ret_addr_q.delete();
        run_cycle();
        check("t5_no_done", done_d_cyc_q.size(), 0);
        rst = 1'b0;
        clear_logs();
        expect_fill(1'b1, 16'h7772);
        repeat (40) run_cycle();
        check("t5_refill_rd0", rd_addr_q.size() > 0 ? rd_addr_q[0] : 16'hFFFF, 16'h7770);
        check("t5_refill_rd_count", rd_addr_q.size(), 8);
        check("t5_refill_done", done_d_cyc_q.size(), 1);
        check_sb("t5", 8);

        // Spurious beats in IDLE, then latency 1 so beats land in ISSUE.
        do_reset();
        lat = 1;
        clear_logs();
        spur = 1'b1;
        repeat (3) run_cycle();
        spur = 1'b0;
        check("t6_idle_strobes", wr_cnt, 0);
        expect_fill(1'b0, 16'h9ABC);
        I_miss_addr = 16'h9ABC; I_miss = 1'b1; req_cyc = cyc;
        repeat (30) run_cycle();
        check("t6_first_rd", rd_addr_q.size() > 0 ? rd_addr_q[0] : 16'hFFFF, 16'h9AB0);
        check("t6_first_beat", first_wr_cyc, req_cyc + 2);
        check("t6_done_count", done_i_cyc_q.size(), 1);
        check("t6_done_lat", done_i_cyc_q.size() > 0 ? done_i_cyc_q[0] - last_wr_cyc : -1, 1);
        check("t6_idle_after", busy, 0);
        check_sb("t6", 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
